// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes follow the MULT/MULTU/DIV/DIVU decode from the instruction.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_adjust.sv
// Conditional two's-complement: result = negate ? -value : value.
// Used both for operand magnitudes and for final sign correction.
module mdu_sign_adjust #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// start in IDLE -> 32 RUN steps -> FINISH writes HI/LO; done pulses the cycle after.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int ITER = MDU_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            we_hi,
  input  logic            we_lo,
  input  logic [XLEN-1:0] wd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mdu_state_t state, state_nxt;
  logic            launch, step, finish;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   addend;
  logic [XLEN-1:0]   a_raw;
  logic              is_div, neg_res, neg_rem, div0;

  logic            in_signed, in_div;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] acc_nxt;

  logic [2*XLEN-1:0] prod_adj;
  logic [XLEN-1:0]   quo_adj, rem_adj;

  assign in_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign in_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign neg_a     = in_signed & srcA[XLEN-1];
  assign neg_b     = in_signed & srcB[XLEN-1];

  mdu_sign_adjust #(.W(XLEN)) u_abs_a (.value(srcA), .negate(neg_a), .result(a_mag));
  mdu_sign_adjust #(.W(XLEN)) u_abs_b (.value(srcB), .negate(neg_b), .result(b_mag));

  mdu_sign_adjust #(.W(2*XLEN)) u_fix_prod (.value(acc), .negate(neg_res), .result(prod_adj));
  mdu_sign_adjust #(.W(XLEN)) u_fix_quo (.value(acc[XLEN-1:0]), .negate(neg_res), .result(quo_adj));
  mdu_sign_adjust #(.W(XLEN)) u_fix_rem (.value(acc[2*XLEN-1:XLEN]), .negate(neg_rem), .result(rem_adj));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_nxt = FINISH;
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // acc is {product high, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : {(XLEN+1){1'b0}});
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, addend};
    acc_nxt   = {mul_sum, acc[XLEN-1:1]};
    if (is_div) begin
      if (!div_diff[XLEN]) acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      addend  <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (launch) begin
        cnt     <= '0;
        acc     <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
        addend  <= in_div ? b_mag : a_mag;
        a_raw   <= srcA;
        is_div  <= in_div;
        neg_res <= neg_a ^ neg_b;
        neg_rem <= neg_a;
        div0    <= in_div && (srcB == '0);
      end else if (state == IDLE) begin
        if (we_hi) hi <= wd;
        if (we_lo) lo <= wd;
      end
      if (step) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nxt;
      end
      if (finish) begin
        if (!is_div) begin
          hi <= prod_adj[2*XLEN-1:XLEN];
          lo <= prod_adj[XLEN-1:0];
        end else if (div0) begin
          hi <= a_raw;
          lo <= '1;
        end else begin
          hi <= rem_adj;
          lo <= quo_adj;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, results, HI/LO writes, reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA, srcB, wd;
  logic        we_hi, we_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is expected high
  // (or one cycle later unless b2b chains straight into the next op).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int poke_at,
                        input bit with_we, input bit b2b);
    logic [31:0] prev_hi, prev_lo;
    int n, bad, dh;
    prev_hi = hi;
    prev_lo = lo;
    start = 1'b1; op = o; srcA = a; srcB = b;
    we_hi = with_we; we_lo = with_we; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    n = 0; bad = 0; dh = 0;
    while (busy && n < 100) begin
      if (hi !== prev_hi || lo !== prev_lo) bad++;
      if (done) dh++;
      if (n == poke_at) begin
        start = 1'b1; op = MDU_MULTU; srcA = 32'd3; srcB = 32'd5;
        we_hi = 1'b1; we_lo = 1'b1; wd = 32'h1234;
      end else begin
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'd33);
    check({tag, "_hold"}, 64'(bad), 64'd0);
    check({tag, "_early_done"}, 64'(dh), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    if (!b2b) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    int n, seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    wd = '0; we_hi = 1'b0; we_lo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, 0, 0);
    run_op("mult_neg",  MDU_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, 0, 0);
    run_op("div_neg",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 0, 0);
    // Second start plus MTHI/MTLO mid-run must not disturb the divide.
    run_op("divu_poke", MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        10, 0, 0);
    // start with MTHI/MTLO in IDLE drops the writes; chain back-to-back.
    run_op("divu_zero", MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, -1, 1, 1);
    run_op("div_ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, -1, 0, 1);
    run_op("div_zero_s", MDU_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, -1, 0, 0);

    we_lo = 1'b1; wd = 32'h1234;
    @(negedge clk);
    we_lo = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_hi", 64'(hi), 64'hFFFF_FFFB);
    we_hi = 1'b1; we_lo = 1'b1; wd = 32'hA5A5_0F0F;
    @(negedge clk);
    we_hi = 1'b0; we_lo = 1'b0;
    check("mthilo_hi", 64'(hi), 64'hA5A5_0F0F);
    check("mthilo_lo", 64'(lo), 64'hA5A5_0F0F);

    start = 1'b1; op = MDU_DIV; srcA = 32'hFFFF_FFF9; srcB = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (n = 0; n < 40; n++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("midrst_quiet", 64'(seen), 64'd0);
    check("midrst_lo_hold", 64'(lo), 64'd0);

    run_op("multu_after_rst", MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
